// File: rtl/fir_interp_pkg.sv
// Shared definitions for the interpolating FIR output path: error-flag bit
// masks and the output pacer FSM state encoding.
package fir_interp_pkg;

    localparam logic [1:0] ERR_OVERFLOW  = 2'h1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'h2;

    typedef enum logic [1:0] {
        PACER_IDLE,
        PACER_PREFILL,
        PACER_RUN
    } pacer_state_e;

endpackage

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count and flush.
// rd_data_o always shows the head word; a write while full is taken only if a read frees a slot.
module fifo_sync_fwft #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      wr_en_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = (count_q == '0);
    assign rd_ok     = rd_en_i && !empty_o;
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fir_interp_out_pacer.sv
// Buffers bursty FIR output samples and re-emits them at a uniform rate set by
// an NCO carry strobe, with sticky overflow/underflow flags.
module fir_interp_out_pacer
    import fir_interp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned PREFILL    = 32,
    parameter int unsigned NCO_WIDTH  = 24,
    parameter int unsigned FILL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         data_val_i,
    input  logic        [NCO_WIDTH-1:0]  rate_i,
    input  logic                         enable_i,
    input  logic                         clr_err_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_val_o,
    output logic        [FILL_WIDTH-1:0] fill_o,
    output logic                         running_o,
    output logic        [1:0]            err_flg_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] PREFILL_CNT = CW'(PREFILL);

    pacer_state_e           state_q;
    logic [NCO_WIDTH-1:0]   acc_q;
    logic [NCO_WIDTH:0]     acc_sum;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   data_val_q;
    logic                   running_q;
    logic [1:0]             err_q;
    logic [1:0]             err_d;
    logic [CW-1:0]          fill_d;

    logic                   tick;
    logic                   pop;
    logic                   underflow;
    logic                   wr_req;
    logic                   wr_acc;
    logic                   overflow;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic [CW-1:0]          fifo_count;

    fifo_sync_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (!enable_i),
        .wr_en_i   (wr_req),
        .wr_data_i (data_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        acc_sum   = {1'b0, acc_q} + {1'b0, rate_i};
        tick      = (state_q == PACER_RUN) && enable_i && acc_sum[NCO_WIDTH];
        pop       = tick && !fifo_empty;
        underflow = tick && fifo_empty;
        wr_req    = data_val_i && enable_i;
        wr_acc    = wr_req && (!fifo_full || pop);
        overflow  = wr_req && fifo_full && !pop;
        // Prefill threshold is judged on the occupancy including this cycle's write.
        fill_d    = fifo_count + CW'(wr_acc);
        err_d     = clr_err_i ? '0 : err_q;
        if (overflow)  err_d = err_d | ERR_OVERFLOW;
        if (underflow) err_d = err_d | ERR_UNDERFLOW;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PACER_IDLE;
            acc_q      <= '0;
            data_q     <= '0;
            data_val_q <= 1'b0;
            running_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            err_q      <= err_d;
            data_val_q <= pop || underflow;
            if (pop) data_q <= fifo_rd_data;

            if (!enable_i) begin
                state_q   <= PACER_IDLE;
                acc_q     <= '0;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    PACER_IDLE: begin
                        state_q   <= PACER_PREFILL;
                        acc_q     <= '0;
                        running_q <= 1'b0;
                    end
                    PACER_PREFILL: begin
                        acc_q <= '0;
                        if (fill_d >= PREFILL_CNT) begin
                            state_q   <= PACER_RUN;
                            running_q <= 1'b1;
                        end else begin
                            running_q <= 1'b0;
                        end
                    end
                    PACER_RUN: begin
                        acc_q <= acc_sum[NCO_WIDTH-1:0];
                        if (underflow) begin
                            state_q   <= PACER_PREFILL;
                            running_q <= 1'b0;
                        end else begin
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= PACER_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_o     = data_q;
    assign data_val_o = data_val_q;
    assign fill_o     = FILL_WIDTH'(fifo_count);
    assign running_o  = running_q;
    assign err_flg_o  = err_q;

endmodule

// File: tb/tb_fir_interp_out_pacer.sv
// Scoreboard bench for fir_interp_out_pacer: accepted writes are queued as
// expected output and compared, in order, against each output strobe.
module tb_fir_interp_out_pacer;

    localparam int DW = 16;
    localparam int NW = 24;
    localparam int FW = 7;
    localparam logic [NW-1:0] RATE16 = 24'h100000;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic signed [DW-1:0] data_i;
    logic                 data_val_i;
    logic [NW-1:0]        rate_i;
    logic                 enable_i;
    logic                 clr_err_i;
    logic signed [DW-1:0] data_o;
    logic                 data_val_o;
    logic [FW-1:0]        fill_o;
    logic                 running_o;
    logic [1:0]           err_flg_o;

    fir_interp_out_pacer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (64),
        .PREFILL    (32),
        .NCO_WIDTH  (NW),
        .FILL_WIDTH (FW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .rate_i     (rate_i),
        .enable_i   (enable_i),
        .clr_err_i  (clr_err_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .fill_o     (fill_o),
        .running_o  (running_o),
        .err_flg_o  (err_flg_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [DW-1:0] exp_q[$];
    logic signed [DW-1:0] last_exp = '0;
    logic signed [DW-1:0] exp_v;
    int  cyc = 0;
    int  last_cyc = 0;
    int  strobe_cnt = 0;
    bit  have_last = 1'b0;
    bit  spc_chk = 1'b0;
    bit  burst_chk = 1'b0;
    int  model_fill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic write_sample(input logic signed [DW-1:0] v, input bit accept);
        @(negedge clk_i);
        data_i     = v;
        data_val_i = 1'b1;
        @(posedge clk_i);
        if (accept) exp_q.push_back(v);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int target;
        target = strobe_cnt + n;
        for (int i = 0; i < budget && strobe_cnt < target; i++) @(posedge clk_i);
        check("strobe_wait", strobe_cnt, target);
    endtask

    task automatic disable_and_check();
        @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        check("dis_dval", data_val_o, 1'b0);
        check("dis_fill", fill_o, 0);
        check("dis_run", running_o, 1'b0);
        exp_q.delete();
        have_last = 1'b0;
    endtask

    // Output monitor: every strobe consumes the next queued sample, or repeats
    // the previous one when nothing is queued (underflow).
    always @(negedge clk_i) begin
        cyc++;
        if (data_val_o) begin
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else                  exp_v = last_exp;
            check("data", data_o, exp_v);
            last_exp = exp_v;
            if (spc_chk && have_last) check("spacing", cyc - last_cyc, 16);
            have_last = 1'b1;
            last_cyc  = cyc;
            if (burst_chk) check("fill_rng", (fill_o >= 1 && fill_o <= 64), 1);
            strobe_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; data_i = '0; data_val_i = 1'b0; rate_i = '0;
        enable_i = 1'b0; clr_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_data", data_o, 0);
        check("rst_dval", data_val_o, 1'b0);
        check("rst_fill", fill_o, 0);
        check("rst_run", running_o, 1'b0);
        check("rst_err", err_flg_o, 2'b00);
        rst_i = 1'b0;

        // Prefill 1..32, paced drain, then underflow repeats the last sample
        @(negedge clk_i);
        enable_i = 1'b1; rate_i = RATE16; spc_chk = 1'b1; have_last = 1'b0;
        for (int i = 1; i <= 31; i++) write_sample(DW'(i), 1'b1);
        #1 check("run_early", running_o, 1'b0);
        write_sample(DW'(32), 1'b1);
        #1 check("run_rise", running_o, 1'b1);
        check("fill_pref", fill_o, 32);
        @(negedge clk_i);
        data_val_i = 1'b0;
        wait_strobes(32, 32 * 16 + 64);
        @(negedge clk_i);
        check("err_clean", err_flg_o, 2'b00);
        wait_strobes(1, 40);
        @(negedge clk_i);
        check("err_uf", err_flg_o, 2'b10);
        check("run_uf", running_o, 1'b0);
        check("fill_uf", fill_o, 0);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
        check("err_clr_uf", err_flg_o, 2'b00);

        // Four bursts of 32 every 512 clocks against one tick per 16 clocks
        have_last = 1'b0; burst_chk = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 32; k++) write_sample(DW'(1000 + b * 32 + k), 1'b1);
            @(negedge clk_i);
            data_val_i = 1'b0;
            repeat (480) @(posedge clk_i);
        end
        @(negedge clk_i);
        check("burst_err", err_flg_o, 2'b00);
        burst_chk = 1'b0; spc_chk = 1'b0;
        disable_and_check();

        // Overflow: no ticks, 70 writes, only the first 64 survive
        rate_i = '0;
        @(negedge clk_i);
        enable_i = 1'b1;
        model_fill = 0;
        for (int i = 0; i < 70; i++) begin
            write_sample(DW'(100 + i), model_fill < 64);
            if (model_fill < 64) model_fill++;
        end
        @(negedge clk_i);
        data_val_i = 1'b0;
        check("ovf_fill", fill_o, 64);
        check("ovf_err", err_flg_o, 2'b01);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
        check("ovf_clr", err_flg_o, 2'b00);
        rate_i = RATE16;
        wait_strobes(64, 64 * 16 + 64);
        disable_and_check();

        // Full FIFO: write lands exactly on the first tick after rate is applied
        rate_i = '0;
        @(negedge clk_i);
        enable_i = 1'b1;
        for (int i = 0; i < 64; i++) write_sample(DW'(200 + i), 1'b1);
        @(negedge clk_i);
        data_val_i = 1'b0;
        rate_i = RATE16;
        repeat (15) @(negedge clk_i);
        data_i = DW'(264); data_val_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back(DW'(264));
        @(negedge clk_i);
        data_val_i = 1'b0;
        check("fullpop_fill", fill_o, 64);
        check("fullpop_err", err_flg_o, 2'b00);
        check("fullpop_dval", data_val_o, 1'b1);
        disable_and_check();

        // Asynchronous reset in the middle of a burst
        rate_i = RATE16;
        @(negedge clk_i);
        enable_i = 1'b1;
        for (int i = 0; i < 50; i++) write_sample(DW'(300 + i), 1'b1);
        @(negedge clk_i);
        data_i = DW'(350); data_val_i = 1'b1;
        #1 rst_i = 1'b1;
        #1;
        check("arst_data", data_o, 0);
        check("arst_dval", data_val_o, 1'b0);
        check("arst_fill", fill_o, 0);
        check("arst_run", running_o, 1'b0);
        check("arst_err", err_flg_o, 2'b00);
        exp_q.delete();
        last_exp = '0;
        data_val_i = 1'b0;
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_fill", fill_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
